hilo_div_ctrl: RTL

Sequencer that owns the ALU's multi-cycle divider and the architectural HI/LO registers for the MIPS core. It accepts DIV/DIVU/MTHI/MTLO/MFHI/MFLO operations from the decode/execute stage and drives the ALU divider. Driving the divider means: holding operands stable, pulsing `divrst`, waiting the fixed iteration count, then reading quotient and remainder through the ALU `ctrl` select. It stalls the pipeline for any HI/LO access while a division is in flight.

---
 rtl/hilo_div_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/hilo_div_ctrl.sv
`timescale 1ns/1ps
// hilo_div_ctrl: sequences the ALU multi-cycle divider and owns HI/LO.
// Ports: clk/rst, op_valid/op/op_a/op_b request, stall/rd_data/hi/lo/busy
// status, alu_a/alu_b/alu_ctrl/alu_divrst to the ALU, alu_out from it.
module hilo_div_ctrl #(
  parameter int unsigned DIV_CYCLES = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  output logic        alu_divrst,
  input  logic [31:0] alu_out
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  localparam logic [2:0] OP_DIVU = 3'b000;
  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_MTHI = 3'b010;
  localparam logic [2:0] OP_MTLO = 3'b011;
  localparam logic [2:0] OP_MFHI = 3'b100;
  localparam logic [2:0] OP_MFLO = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    REM
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     hi_q;
  logic [31:0]     lo_q;
  logic [31:0]     a_q;
  logic [31:0]     b_q;
  logic [3:0]      ctrl_q;
  logic            divrst_q;
  logic            busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= 4'b1100;
      divrst_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      divrst_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (op_valid) begin
            case (op)
              OP_DIVU, OP_DIV: begin
                if (op_b != '0) begin
                  a_q      <= op_a;
                  b_q      <= op_b;
                  // op[0] selects the signed divider codes
                  ctrl_q   <= {2'b11, op[0], 1'b0};
                  divrst_q <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= START;
                end else begin
                  // divide by zero resolves here without the ALU
                  lo_q <= '1;
                  hi_q <= op_a;
                end
              end
              OP_MTHI: hi_q <= op_a;
              OP_MTLO: lo_q <= op_a;
              default: ;
            endcase
          end
        end
        START: begin
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(DIV_CYCLES - 1)) begin
            lo_q      <= alu_out;
            ctrl_q[0] <= 1'b1;
            state_q   <= REM;
          end
        end
        REM: begin
          hi_q      <= alu_out;
          ctrl_q[0] <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (op_valid && state_q == IDLE) begin
      if (op == OP_MFHI) rd_data = hi_q;
      else if (op == OP_MFLO) rd_data = lo_q;
    end
  end

  assign stall      = op_valid & busy_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign busy       = busy_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_ctrl   = ctrl_q;
  assign alu_divrst = divrst_q;

endmodule
